div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the execute stage; serves MIPS DIV/DIVU.
- Consumes the forwarded execute-stage operands.
- Produces a 64-bit {hi,lo} = {remainder,quotient} pair that feeds the hilo register write path.
- Pipeline control holds the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- cancel  input  1  abort in-flight operation (pipeline flush).
- a  input  WIDTH  dividend; sampled with start.
- b  input  WIDTH  divisor; sampled with start.
- busy  output  1  operation in progress.
- ready  output  1  one-cycle pulse: result valid.
- result  output  2*WIDTH  {remainder, quotient}; upper half goes to hi, lower half to lo.

Behaviour:
- Reset: state=IDLE, busy=0, ready=0, result=0, internal registers cleared. Reset wins over start/cancel in the same cycle and aborts any operation mid-flight.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and cancel=0: latch |a|, |b|, sign flags (signed_div & a[MSB], signed_div & b[MSB]), clear partial remainder, iteration counter=0.
  - b!=0: go to RUN.
  - b==0: go to DONE.
  - start=1 with cancel=1: ignored.
- RUN: busy=1. Each cycle shifts one quotient bit in (trial subtract of divisor from {rem,next dividend bit}, restore on negative). Counter increments. After WIDTH iterations, go to DONE.
- DONE: ready=1 and busy=0 for exactly this cycle. result is written on entry to DONE, then returns to IDLE.
- Latency (start sampled at edge of cycle 0):
  - busy=1 in cycles 1..WIDTH.
  - ready=1 in cycle WIDTH+1, so 33 cycles for WIDTH=32.
  - Divide-by-zero: ready=1 in cycle 1, busy never asserted.
- Sign fix-up, applied when writing result:
  - Quotient negated if the dividend and divisor sign flags differ.
  - Remainder negated if the dividend sign flag is set (remainder takes the dividend's sign).
  - Unsigned mode never negates.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (two's-complement wrap); no exception.
- Divide-by-zero (defined, not trapped): result = {a, all-ones}, i.e. remainder=dividend, quotient=0xFFFFFFFF, in both modes.
- result holds its value after ready until the next result write; it does not change during RUN.
- start while in RUN or DONE: ignored, not queued.
- cancel in RUN or DONE: next state IDLE, busy=0, ready not asserted, result unchanged. cancel in IDLE has no effect.
- Operands a, b, signed_div may change freely after the start cycle.

Test Plan:
- Unsigned: start, a=100, b=7, signed_div=0 -> busy high cycles 1..32; ready pulse in cycle 33 only; result = {32'd2, 32'd14}.
- Signed: a=0xFFFFFFF9 (-7), b=2 -> result = {0xFFFFFFFF, 0xFFFFFFFD}. Then a=7, b=0xFFFFFFFE -> result = {0x00000001, 0xFFFFFFFD}.
- Unsigned large: a=0xFFFFFFFF, b=0x10 -> result = {0x0000000F, 0x0FFFFFFF}. Same operands with signed_div=1 -> result = {0xFFFFFFFF, 0x00000000}.
- Edge values:
  - Signed 0x80000000 / 0xFFFFFFFF -> result = {0x00000000, 0x80000000}.
  - a=5, b=0 -> ready in cycle 1, busy never high, result = {0x00000005, 0xFFFFFFFF}.
- Control:
  - cancel asserted in cycle 10 of a 100/7 run -> busy=0 from cycle 11, no ready pulse, result keeps its prior value.
  - Immediate new start 9/3 after the cancel -> result = {0, 3} exactly 33 cycles after that start.
  - start re-asserted during RUN -> ignored; the first operation completes normally.
- Reset: rst asserted in cycle 15 of a run -> next cycle busy=0, ready=0, result=0; no ready pulse follows.

Source files
------------

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - operand/result handshake bundle between execute stage and div_unit
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic                 signed_div;
   logic                 cancel;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 ready;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, signed_div, cancel, a, b,
      input  busy, ready, result
   );

   modport slave (
      input  start, signed_div, cancel, a, b,
      output busy, ready, result
   );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider producing {remainder, quotient} for hi/lo
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   state_t               state_next;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     dvsr;
   logic [CW-1:0]        cnt;
   logic                 neg_q;
   logic                 neg_r;
   logic [2*WIDTH-1:0]   result_q;

   logic                 load;
   logic                 step;
   logic                 busy_c;
   logic                 ready_c;
   logic                 a_neg;
   logic                 b_neg;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       rem_shift;
   logic [WIDTH:0]       diff;
   logic                 fits;
   logic [WIDTH-1:0]     rem_new;
   logic [WIDTH-1:0]     quo_new;
   logic [WIDTH-1:0]     quo_fix;
   logic [WIDTH-1:0]     rem_fix;

   always_comb begin
      a_neg = bus.signed_div & bus.a[WIDTH-1];
      b_neg = bus.signed_div & bus.b[WIDTH-1];
      a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
      b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;
   end

   // Partial remainder stays below the divisor, so a borrow out of bit WIDTH means "restore".
   always_comb begin
      rem_shift = {rem, quo[WIDTH-1]};
      diff      = rem_shift - {1'b0, dvsr};
      fits      = ~diff[WIDTH];
      rem_new   = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      quo_new   = {quo[WIDTH-2:0], fits};
      quo_fix   = neg_q ? (~quo_new + 1'b1) : quo_new;
      rem_fix   = neg_r ? (~rem_new + 1'b1) : rem_new;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      busy_c     = 1'b0;
      ready_c    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.cancel) begin
               load       = 1'b1;
               state_next = (bus.b == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy_c = 1'b1;
            if (bus.cancel) begin
               state_next = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == LAST) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            ready_c    = !bus.cancel;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Result is only written on entry to DONE, so it holds steady through RUN and after ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         quo      <= '0;
         rem      <= '0;
         dvsr     <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_q <= '0;
      end else if (load) begin
         quo   <= a_mag;
         rem   <= '0;
         dvsr  <= b_mag;
         cnt   <= '0;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
         if (bus.b == '0) begin
            result_q <= {bus.a, {WIDTH{1'b1}}};
         end
      end else if (step) begin
         quo <= quo_new;
         rem <= rem_new;
         cnt <= cnt + 1'b1;
         if (cnt == LAST) begin
            result_q <= {rem_fix, quo_fix};
         end
      end
   end

   assign bus.busy   = busy_c;
   assign bus.ready  = ready_c;
   assign bus.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit against an arithmetic reference
module tb_div_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_unit_if #(.WIDTH(W)) bus ();
   div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int vectors = 0;
   int miscompares = 0;

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sg);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Issues one division right after a falling edge and watches a fixed window of cycles.
   task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input bit sg, output logic [63:0] got);
      logic [63:0] exp, prev;
      int exp_rdy, rdy_cycle, rdy_cnt, busy_cnt, held_bad;
      exp     = model(a, b, sg);
      exp_rdy = (b == 32'd0) ? 1 : W + 1;
      prev    = bus.result;
      got     = bus.result;
      bus.a = a; bus.b = b; bus.signed_div = sg; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.signed_div = 1'($urandom_range(0, 1));
      rdy_cycle = 0; rdy_cnt = 0; busy_cnt = 0; held_bad = 0;
      for (int c = 1; c <= W + 4; c++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.ready === 1'b1) begin
            rdy_cnt++;
            if (rdy_cycle == 0) begin
               rdy_cycle = c;
               got = bus.result;
            end
         end else if (rdy_cycle == 0 && bus.result !== prev) begin
            held_bad++;
         end
      end
      vectors++;
      if (rdy_cycle !== exp_rdy) begin
         miscompares++;
         $display("FAIL %s ready_cycle: got %0d expected %0d", name, rdy_cycle, exp_rdy);
      end
      vectors++;
      if (rdy_cnt !== 1) begin
         miscompares++;
         $display("FAIL %s ready_pulses: got %0d expected 1", name, rdy_cnt);
      end
      vectors++;
      if (busy_cnt !== exp_rdy - 1) begin
         miscompares++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_rdy - 1);
      end
      vectors++;
      if (held_bad !== 0) begin
         miscompares++;
         $display("FAIL %s result_held: got %0d changes expected 0", name, held_bad);
      end
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s result: got %h expected %h (a=%h b=%h s=%0d)", name, got, exp, a, b, sg);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.cancel = 1'b0; bus.signed_div = 1'b0; bus.a = '0; bus.b = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.busy, bus.ready, bus.result} !== 66'd0) begin
         miscompares++;
         $display("FAIL reset_state: got busy=%b ready=%b result=%h expected 0 0 0", bus.busy, bus.ready, bus.result);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [63:0] got;
      do_div("udiv_100_7", 32'd100, 32'd7, 1'b0, got);
      vectors++;
      if (got !== {32'd2, 32'd14}) begin
         miscompares++;
         $display("FAIL udiv_100_7_const: got %h expected %h", got, {32'd2, 32'd14});
      end
      do_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, got);
      vectors++;
      if (got !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         miscompares++;
         $display("FAIL sdiv_m7_2_const: got %h expected %h", got, 64'hFFFF_FFFF_FFFF_FFFD);
      end
      do_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, got);
      vectors++;
      if (got !== 64'h0000_0001_FFFF_FFFD) begin
         miscompares++;
         $display("FAIL sdiv_7_m2_const: got %h expected %h", got, 64'h0000_0001_FFFF_FFFD);
      end
      do_div("udiv_large", 32'hFFFF_FFFF, 32'h10, 1'b0, got);
      vectors++;
      if (got !== 64'h0000_000F_0FFF_FFFF) begin
         miscompares++;
         $display("FAIL udiv_large_const: got %h expected %h", got, 64'h0000_000F_0FFF_FFFF);
      end
      do_div("sdiv_large", 32'hFFFF_FFFF, 32'h10, 1'b1, got);
      vectors++;
      if (got !== 64'hFFFF_FFFF_0000_0000) begin
         miscompares++;
         $display("FAIL sdiv_large_const: got %h expected %h", got, 64'hFFFF_FFFF_0000_0000);
      end
      do_div("sdiv_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, got);
      vectors++;
      if (got !== 64'h0000_0000_8000_0000) begin
         miscompares++;
         $display("FAIL sdiv_overflow_const: got %h expected %h", got, 64'h0000_0000_8000_0000);
      end
      do_div("div_zero", 32'd5, 32'd0, 1'b0, got);
      vectors++;
      if (got !== 64'h0000_0005_FFFF_FFFF) begin
         miscompares++;
         $display("FAIL div_zero_const: got %h expected %h", got, 64'h0000_0005_FFFF_FFFF);
      end
      do_div("sdiv_zero_neg", 32'hFFFF_FF00, 32'd0, 1'b1, got);
   endtask

   task automatic test_cancel();
      logic [63:0] prev, got;
      int rdy_cnt;
      prev = bus.result;
      rdy_cnt = 0;
      bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) rdy_cnt++;
         if (c == 10) bus.cancel = 1'b1;
      end
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL cancel_busy: got %b expected 0", bus.busy);
      end
      vectors++;
      if (rdy_cnt !== 0) begin
         miscompares++;
         $display("FAIL cancel_ready: got %0d pulses expected 0", rdy_cnt);
      end
      vectors++;
      if (bus.result !== prev) begin
         miscompares++;
         $display("FAIL cancel_result: got %h expected %h", bus.result, prev);
      end
      bus.cancel = 1'b0;
      do_div("after_cancel_9_3", 32'd9, 32'd3, 1'b0, got);
      vectors++;
      if (got !== {32'd0, 32'd3}) begin
         miscompares++;
         $display("FAIL after_cancel_const: got %h expected %h", got, {32'd0, 32'd3});
      end
   endtask

   task automatic test_start_during_run();
      logic [63:0] got;
      int rdy_cnt, rdy_cycle;
      rdy_cnt = 0; rdy_cycle = 0; got = '0;
      bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 75; c++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) begin
            rdy_cnt++;
            if (rdy_cycle == 0) begin
               rdy_cycle = c;
               got = bus.result;
            end
         end
         if (c == 5) begin
            bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
      end
      vectors++;
      if (rdy_cycle !== W + 1 || rdy_cnt !== 1) begin
         miscompares++;
         $display("FAIL restart_ignored_ready: got cycle %0d pulses %0d expected cycle %0d pulses 1", rdy_cycle, rdy_cnt, W + 1);
      end
      vectors++;
      if (got !== {32'd2, 32'd14}) begin
         miscompares++;
         $display("FAIL restart_ignored_result: got %h expected %h", got, {32'd2, 32'd14});
      end
   endtask

   task automatic test_reset_midrun();
      int rdy_cnt;
      rdy_cnt = 0;
      bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 15) rst = 1'b1;
      end
      vectors++;
      if ({bus.busy, bus.ready, bus.result} !== 66'd0) begin
         miscompares++;
         $display("FAIL reset_midrun_state: got busy=%b ready=%b result=%h expected 0 0 0", bus.busy, bus.ready, bus.result);
      end
      rst = 1'b0;
      for (int c = 17; c <= 50; c++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) rdy_cnt++;
      end
      vectors++;
      if (rdy_cnt !== 0) begin
         miscompares++;
         $display("FAIL reset_midrun_ready: got %0d pulses expected 0", rdy_cnt);
      end
   endtask

   task automatic test_random();
      logic [63:0] got;
      logic [31:0] ra, rb;
      bit sg;
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = -32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         sg = 1'($urandom_range(0, 1));
         do_div("random", ra, rb, sg, got);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_cancel();
      test_start_during_run();
      test_reset_midrun();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
